// File: rtl/cu_mem_arbiter_if.sv
// Bundle of compute-unit request/response lanes and the shared memory port.
// The arbiter sits on the slave side; compute units and memory drive the master side.
interface cu_mem_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_is_load;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*5-1:0]  req_rd;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [4:0]            resp_rd;
    logic [31:0]           resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_is_load;
    logic [31:0]           mem_req_addr;
    logic [31:0]           mem_req_wdata;
    logic [4:0]            mem_req_rd;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [4:0]            mem_resp_rd;
    logic [31:0]           mem_resp_data;

    logic [CNT_W-1:0]      outstanding;
    logic                  err_resp_underflow;

    modport master (
        output req_valid, req_is_load, req_addr, req_wdata, req_rd,
        input  req_ready, resp_valid, resp_rd, resp_data,
        input  mem_req_valid, mem_req_is_load, mem_req_addr, mem_req_wdata, mem_req_rd,
        output mem_req_ready, mem_resp_valid, mem_resp_rd, mem_resp_data,
        input  outstanding, err_resp_underflow
    );

    modport slave (
        input  req_valid, req_is_load, req_addr, req_wdata, req_rd,
        output req_ready, resp_valid, resp_rd, resp_data,
        output mem_req_valid, mem_req_is_load, mem_req_addr, mem_req_wdata, mem_req_rd,
        input  mem_req_ready, mem_resp_valid, mem_resp_rd, mem_resp_data,
        output outstanding, err_resp_underflow
    );
endinterface

// File: rtl/cu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ compute units.
// Loads record their owner in an ID FIFO so in-order memory responses are routed
// back to the issuer; a credit counter bounds the number of unanswered loads.
module cu_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cu_mem_arbiter_if.slave bus
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CREDIT_LIMIT = CNT_W'(MAX_OUTSTANDING);

    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic               grant_found;
    logic               grant_fire;
    logic               stage_free;
    logic               credit_ok;
    logic [NUM_REQ-1:0] eligible;

    logic               mem_req_valid_q;
    logic               mem_req_is_load_q;
    logic [31:0]        mem_req_addr_q;
    logic [31:0]        mem_req_wdata_q;
    logic [4:0]         mem_req_rd_q;

    logic [IDW-1:0]     id_fifo [MAX_OUTSTANDING];
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   outstanding_q;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    logic [NUM_REQ-1:0] resp_valid_q;
    logic [4:0]         resp_rd_q;
    logic [31:0]        resp_data_q;
    logic               err_q;

    assign stage_free = !mem_req_valid_q || bus.mem_req_ready;
    assign credit_ok  = outstanding_q < CREDIT_LIMIT;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign grant_fire = rst_n && stage_free && grant_found;
    assign push       = grant_fire && bus.req_is_load[grant_id];
    assign pop        = bus.mem_resp_valid && !fifo_empty;

    // A unit may compete if it has a store, or a load while credits remain
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (!bus.req_is_load[i] || credit_ok);
        end
    end

    // Round-robin search starting just above the most recently granted unit
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Output register toward memory: capture on grant, drop valid once drained with nothing new
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_valid_q   <= 1'b0;
            mem_req_is_load_q <= 1'b0;
            mem_req_addr_q    <= '0;
            mem_req_wdata_q   <= '0;
            mem_req_rd_q      <= '0;
            last_grant        <= IDW'(NUM_REQ - 1);
        end else if (grant_fire) begin
            mem_req_valid_q   <= 1'b1;
            mem_req_is_load_q <= bus.req_is_load[grant_id];
            mem_req_addr_q    <= bus.req_addr[int'(grant_id)*32 +: 32];
            mem_req_wdata_q   <= bus.req_wdata[int'(grant_id)*32 +: 32];
            mem_req_rd_q      <= bus.req_rd[int'(grant_id)*5 +: 5];
            last_grant        <= grant_id;
        end else if (stage_free) begin
            mem_req_valid_q   <= 1'b0;
        end
    end

    // Owner FIFO and credit counter; loads are booked at grant time, released on response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding_q <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr[PTR_W-1:0]] <= grant_id;
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Route each memory response to the FIFO head one cycle later; flag responses with no owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            if (pop) begin
                resp_valid_q <= NUM_REQ'(1) << id_fifo[rd_ptr[PTR_W-1:0]];
                resp_rd_q    <= bus.mem_resp_rd;
                resp_data_q  <= bus.mem_resp_data;
            end
            if (bus.mem_resp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready          = grant_fire ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.mem_req_valid      = mem_req_valid_q;
    assign bus.mem_req_is_load    = mem_req_is_load_q;
    assign bus.mem_req_addr       = mem_req_addr_q;
    assign bus.mem_req_wdata      = mem_req_wdata_q;
    assign bus.mem_req_rd         = mem_req_rd_q;
    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_rd            = resp_rd_q;
    assign bus.resp_data          = resp_data_q;
    assign bus.outstanding        = outstanding_q;
    assign bus.err_resp_underflow = err_q;
endmodule

// File: tb/tb_cu_mem_arbiter.sv
// Self-checking bench for cu_mem_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_cu_mem_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cu_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) bus ();

    cu_mem_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // compute-unit and memory stimulus state
    logic        u_valid [NUM_REQ];
    logic        u_load  [NUM_REQ];
    logic [31:0] u_addr  [NUM_REQ];
    logic [31:0] u_wdata [NUM_REQ];
    logic [4:0]  u_rd    [NUM_REQ];
    logic        mem_ready;
    logic        mem_rvalid;
    logic [4:0]  mem_rrd;
    logic [31:0] mem_rdata;
    logic [4:0]  mem_q [$];

    // reference model: request slot contents, owner list, response slot, sticky error
    logic               m_valid;
    logic               m_load;
    logic [31:0]        m_addr;
    logic [31:0]        m_wdata;
    logic [4:0]         m_rd;
    int                 m_last;
    int                 owners [$];
    logic [NUM_REQ-1:0] m_resp_valid;
    logic [4:0]         m_resp_rd;
    logic [31:0]        m_resp_data;
    logic               m_err;

    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]          = u_valid[i];
            bus.req_is_load[i]        = u_load[i];
            bus.req_addr[32*i +: 32]  = u_addr[i];
            bus.req_wdata[32*i +: 32] = u_wdata[i];
            bus.req_rd[5*i +: 5]      = u_rd[i];
        end
        bus.mem_req_ready  = mem_ready;
        bus.mem_resp_valid = mem_rvalid;
        bus.mem_resp_rd    = mem_rrd;
        bus.mem_resp_data  = mem_rdata;
    endtask

    task automatic setUnit(input int i, input logic ld, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        u_valid[i] = 1'b1;
        u_load[i]  = ld;
        u_addr[i]  = addr;
        u_wdata[i] = wdata;
        u_rd[i]    = rd;
    endtask

    function automatic void modelReset();
        m_valid      = 1'b0;
        m_load       = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        m_rd         = '0;
        m_last       = NUM_REQ - 1;
        owners.delete();
        m_resp_valid = '0;
        m_resp_rd    = '0;
        m_resp_data  = '0;
        m_err        = 1'b0;
    endfunction

    // Which unit is granted this cycle, or -1
    function automatic int modelGrant();
        if (!rst_n) return -1;
        if (m_valid && !mem_ready) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i = (m_last + k) % NUM_REQ;
            if (u_valid[i] && (!u_load[i] || owners.size() < MAX_OUT)) return i;
        end
        return -1;
    endfunction

    task automatic modelUpdate(input int g);
        if (m_valid && mem_ready && m_load) mem_q.push_back(m_rd);
        if (!rst_n) begin
            modelReset();
        end else begin
            m_resp_valid = '0;
            if (mem_rvalid) begin
                if (owners.size() > 0) begin
                    int h = owners.pop_front();
                    m_resp_valid = NUM_REQ'(1) << h;
                    m_resp_rd    = mem_rrd;
                    m_resp_data  = mem_rdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_load  = u_load[g];
                m_addr  = u_addr[g];
                m_wdata = u_wdata[g];
                m_rd    = u_rd[g];
                m_last  = g;
                if (u_load[g]) owners.push_back(g);
                u_valid[g] = 1'b0;
            end else if (!m_valid || mem_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: drive, compare at the falling edge, advance the model, return just after the rising edge
    task automatic stepCycle();
        int g;
        applyStimulus();
        @(negedge clk);
        g = modelGrant();
        checkOutput("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkOutput("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput("mem_req_is_load", 32'(bus.mem_req_is_load), 32'(m_load));
            checkOutput("mem_req_addr", bus.mem_req_addr, m_addr);
            checkOutput("mem_req_wdata", bus.mem_req_wdata, m_wdata);
            checkOutput("mem_req_rd", 32'(bus.mem_req_rd), 32'(m_rd));
        end
        checkOutput("outstanding", 32'(bus.outstanding), owners.size());
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'(m_resp_valid));
        if (m_resp_valid != '0) begin
            checkOutput("resp_rd", 32'(bus.resp_rd), 32'(m_resp_rd));
            checkOutput("resp_data", bus.resp_data, m_resp_data);
        end
        checkOutput("err_resp_underflow", 32'(bus.err_resp_underflow), 32'(m_err));
        modelUpdate(g);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        mem_rvalid = 1'b0;
        rst_n = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("rst_req_ready", 32'(bus.req_ready), 0);
        checkOutput("rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
        checkOutput("rst_mem_req_is_load", 32'(bus.mem_req_is_load), 0);
        checkOutput("rst_mem_req_addr", bus.mem_req_addr, 0);
        checkOutput("rst_mem_req_wdata", bus.mem_req_wdata, 0);
        checkOutput("rst_mem_req_rd", 32'(bus.mem_req_rd), 0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 0);
        checkOutput("rst_resp_rd", 32'(bus.resp_rd), 0);
        checkOutput("rst_resp_data", bus.resp_data, 0);
        checkOutput("rst_outstanding", 32'(bus.outstanding), 0);
        checkOutput("rst_err", 32'(bus.err_resp_underflow), 0);
        rst_n = 1'b1;
    endtask

    task automatic randomStep();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!u_valid[i] && $urandom_range(0, 9) < 4) begin
                setUnit(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom));
            end
        end
        mem_ready = ($urandom_range(0, 3) != 0);
        if (mem_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            mem_rvalid = 1'b1;
            mem_rrd    = mem_q.pop_front();
            mem_rdata  = $urandom;
        end else begin
            mem_rvalid = 1'b0;
        end
        stepCycle();
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            u_valid[i] = 1'b0;
            u_load[i]  = 1'b0;
            u_addr[i]  = '0;
            u_wdata[i] = '0;
            u_rd[i]    = '0;
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rrd    = '0;
        mem_rdata  = '0;
        rst_n      = 1'b0;
        modelReset();
        applyStimulus();
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] single load");
        mem_ready = 1'b1;
        setUnit(1, 1'b1, 32'hFFFF_F800, 32'h0, 5'd5);
        stepCycle();
        checkOutput("single_outstanding_1", 32'(bus.outstanding), 1);
        checkOutput("single_mem_addr", bus.mem_req_addr, 32'hFFFF_F800);
        checkOutput("single_mem_rd", 32'(bus.mem_req_rd), 5);
        stepCycle();
        mem_rvalid = 1'b1; mem_rrd = 5'd5; mem_rdata = 32'd12;
        stepCycle();
        mem_rvalid = 1'b0;
        checkOutput("single_resp_valid", 32'(bus.resp_valid), 32'b0010);
        checkOutput("single_resp_rd", 32'(bus.resp_rd), 5);
        checkOutput("single_resp_data", bus.resp_data, 12);
        checkOutput("single_outstanding_0", 32'(bus.outstanding), 0);
        stepCycle();

        $display("[TB] round robin and backpressure");
        doReset();
        mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!u_valid[i]) setUnit(i, 1'b0, 32'h1000 + 32'(i) * 4, 32'hA000 + 32'(i), 5'd0);
            end
            stepCycle();
            checkOutput("rr_order", bus.mem_req_addr, 32'h1000 + 32'(k % NUM_REQ) * 4);
            checkOutput("rr_outstanding", 32'(bus.outstanding), 0);
        end
        hold_addr  = m_addr;
        hold_wdata = m_wdata;
        mem_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("bp_hold_addr", bus.mem_req_addr, hold_addr);
            checkOutput("bp_hold_wdata", bus.mem_req_wdata, hold_wdata);
            checkOutput("bp_req_ready", 32'(bus.req_ready), 0);
        end
        mem_ready = 1'b1;
        stepCycle();
        checkOutput("bp_resume", bus.mem_req_addr, 32'h1008);

        $display("[TB] credit limit");
        doReset();
        for (int i = 0; i < NUM_REQ; i++) u_valid[i] = 1'b0;
        mem_ready = 1'b1;
        setUnit(0, 1'b1, 32'h200, 32'h0, 5'd1);
        stepCycle();
        setUnit(0, 1'b1, 32'h204, 32'h0, 5'd2);
        stepCycle();
        setUnit(0, 1'b1, 32'h208, 32'h0, 5'd3);
        setUnit(2, 1'b0, 32'h300, 32'h55, 5'd0);
        stepCycle();
        checkOutput("credit_store_passes", bus.mem_req_addr, 32'h300);
        checkOutput("credit_full", 32'(bus.outstanding), 2);
        stepCycle();
        checkOutput("credit_stalled", 32'(bus.mem_req_valid), 0);
        mem_rvalid = 1'b1; mem_rrd = 5'd1; mem_rdata = 32'd55;
        stepCycle();
        mem_rvalid = 1'b0;
        checkOutput("credit_release", 32'(bus.outstanding), 1);
        checkOutput("credit_resp_owner", 32'(bus.resp_valid), 32'b0001);
        stepCycle();
        checkOutput("credit_third_load", 32'(bus.mem_req_rd), 3);
        checkOutput("credit_refill", 32'(bus.outstanding), 2);
        mem_rvalid = 1'b1; mem_rrd = 5'd2; mem_rdata = 32'd66;
        stepCycle();
        mem_rrd = 5'd3; mem_rdata = 32'd77;
        stepCycle();
        mem_rvalid = 1'b0;
        stepCycle();
        checkOutput("credit_drained", 32'(bus.outstanding), 0);

        $display("[TB] response routing");
        doReset();
        mem_ready = 1'b1;
        setUnit(2, 1'b1, 32'h400, 32'h0, 5'd7);
        stepCycle();
        setUnit(0, 1'b1, 32'h404, 32'h0, 5'd8);
        stepCycle();
        setUnit(3, 1'b1, 32'h408, 32'h0, 5'd9);
        mem_rvalid = 1'b1; mem_rrd = 5'd7; mem_rdata = 32'd100;
        stepCycle();
        checkOutput("route_a_valid", 32'(bus.resp_valid), 32'b0100);
        checkOutput("route_a_data", bus.resp_data, 100);
        mem_rrd = 5'd8; mem_rdata = 32'd200;
        stepCycle();
        checkOutput("route_b_valid", 32'(bus.resp_valid), 32'b0001);
        checkOutput("route_b_rd", 32'(bus.resp_rd), 8);
        checkOutput("route_push_pop", 32'(bus.outstanding), 1);
        mem_rrd = 5'd9; mem_rdata = 32'd300;
        stepCycle();
        mem_rvalid = 1'b0;
        checkOutput("route_c_valid", 32'(bus.resp_valid), 32'b1000);
        checkOutput("route_c_data", bus.resp_data, 300);
        checkOutput("route_c_outstanding", 32'(bus.outstanding), 0);
        stepCycle();

        $display("[TB] spurious response");
        mem_rvalid = 1'b1; mem_rrd = 5'd4; mem_rdata = 32'hDEAD;
        stepCycle();
        mem_rvalid = 1'b0;
        checkOutput("spur_resp_valid", 32'(bus.resp_valid), 0);
        checkOutput("spur_outstanding", 32'(bus.outstanding), 0);
        checkOutput("spur_err", 32'(bus.err_resp_underflow), 1);
        stepCycle();
        stepCycle();
        checkOutput("spur_err_sticky", 32'(bus.err_resp_underflow), 1);
        doReset();

        $display("[TB] random traffic");
        mem_q.delete();
        for (int i = 0; i < NUM_REQ; i++) u_valid[i] = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) doReset();
            randomStep();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
